button_debounce: RTL and testbench

//  Consumes clk_deb from the clock divider (clk/65536 square wave) as a sample strobe, not a clock.

---
 rtl/button_debounce.sv | 172 +++++++++++++++++
 tb/tb_button_debounce.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   Debounces one raw push-button sampled on rising edges of a slow divider
//   output (clk_deb), producing a clean level and one-clk press/release pulses.
//   clk_deb is treated purely as a sample strobe; all logic runs on clk.
//
//   Optional feature: define AUTO_REPEAT_EN to make a held button emit extra
//   btn_press pulses after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active low
//   clk_deb      in   slow divider output; each rising edge is one sample tick
//   btn_in       in   raw asynchronous button, 1 = pressed
//   btn_level    out  debounced level (registered)
//   btn_press    out  one-clk pulse on accepted 0->1 (and auto-repeat)
//   btn_release  out  one-clk pulse on accepted 1->0
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned STABLE_CNT   = 4,
    parameter int unsigned REPEAT_DELAY = 32,
    parameter int unsigned REPEAT_RATE  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_deb,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CNT);

    typedef enum logic [1:0] {
        S_RELEASED   = 2'd0,
        S_PRESS_WAIT = 2'd1,
        S_PRESSED    = 2'd2,
        S_REL_WAIT   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       btn_sync;
    logic [1:0]       deb_sync;
    logic             deb_prev;
    logic             tick;
    logic             sample;

    // Two-flop synchronizers plus one history flop for clk_deb edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= 2'b00;
            deb_sync <= 2'b00;
            deb_prev <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[0], btn_in};
            deb_sync <= {deb_sync[0], clk_deb};
            deb_prev <= deb_sync[1];
        end
    end

    assign tick   = deb_sync[1] & ~deb_prev;
    assign sample = btn_sync[1];

`ifdef AUTO_REPEAT_EN
    localparam logic [7:0] REP_DELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0] REP_RATE  = 8'(REPEAT_RATE);

    // rep_armed: first repeat already issued, so rep_cnt now measures REP_RATE
    logic [7:0] rep_cnt;
    logic       rep_armed;
`else
    logic unused_cfg;
    assign unused_cfg = ^{8'(REPEAT_DELAY), 8'(REPEAT_RATE)};
`endif

    // Debounce FSM; advances only on ticks, outputs registered alongside state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RELEASED;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt     <= 8'd0;
            rep_armed   <= 1'b0;
`endif
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (tick) begin
                case (state)
                    S_RELEASED: begin
                        if (sample) begin
                            state <= S_PRESS_WAIT;
                            cnt   <= CNT_ONE;
                        end
                    end
                    S_PRESS_WAIT: begin
                        if (!sample) begin
                            state <= S_RELEASED;
                            cnt   <= '0;
                        end else if (cnt >= CNT_LAST) begin
                            state     <= S_PRESSED;
                            cnt       <= '0;
                            btn_level <= 1'b1;
                            btn_press <= 1'b1;
`ifdef AUTO_REPEAT_EN
                            rep_cnt   <= 8'd0;
                            rep_armed <= 1'b0;
`endif
                        end else if (cnt < CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_PRESSED: begin
                        if (!sample) begin
                            state <= S_REL_WAIT;
                            cnt   <= CNT_ONE;
                        end
`ifdef AUTO_REPEAT_EN
                        else if (!rep_armed) begin
                            if (rep_cnt + 8'd1 == REP_DELAY) begin
                                btn_press <= 1'b1;
                                rep_armed <= 1'b1;
                                rep_cnt   <= 8'd0;
                            end else begin
                                rep_cnt <= rep_cnt + 8'd1;
                            end
                        end else begin
                            if (rep_cnt + 8'd1 == REP_RATE) begin
                                btn_press <= 1'b1;
                                rep_cnt   <= 8'd0;
                            end else begin
                                rep_cnt <= rep_cnt + 8'd1;
                            end
                        end
`endif
                    end
                    S_REL_WAIT: begin
                        // Repeat count is parked here so a bounce back resumes it
                        if (sample) begin
                            state <= S_PRESSED;
                            cnt   <= '0;
                        end else if (cnt >= CNT_LAST) begin
                            state       <= S_RELEASED;
                            cnt         <= '0;
                            btn_level   <= 1'b0;
                            btn_release <= 1'b1;
`ifdef AUTO_REPEAT_EN
                            rep_cnt     <= 8'd0;
                            rep_armed   <= 1'b0;
`endif
                        end else if (cnt < CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= S_RELEASED;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//   Self-checking bench for button_debounce (STABLE_CNT=4). clk_deb toggles
//   every 8 clk. A per-tick reference model derives expectations from the
//   acceptance rule: the level flips once the last STABLE_CNT samples all
//   disagree with it. Define AUTO_REPEAT_EN to also model auto-repeat.
// -----------------------------------------------------------------------------
module tb_button_debounce;

    localparam int STABLE = 4;
    localparam int DELAY  = 32;
    localparam int RATE   = 8;

    logic clk;
    logic rst_n;
    logic clk_deb;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    button_debounce #(
        .STABLE_CNT  (STABLE),
        .REPEAT_DELAY(DELAY),
        .REPEAT_RATE (RATE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_deb    (clk_deb),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running pulse totals observed on the falling edge
    int tot_press;
    int tot_rel;
    int both_hi;
    initial begin
        tot_press = 0;
        tot_rel   = 0;
        both_hi   = 0;
    end
    always @(negedge clk) begin
        if (btn_press === 1'b1)   tot_press = tot_press + 1;
        if (btn_release === 1'b1) tot_rel   = tot_rel + 1;
        if (btn_press === 1'b1 && btn_release === 1'b1) both_hi = both_hi + 1;
    end

    int n_checks;
    int n_pass;

    // Reference model state
    int m_level;
    bit hist[$];
    int held;
    bit prev_s;
    int exp_np;
    int exp_nr;
    bit exp_lvl;

    // Observations from the last tick
    int np;
    int nr;
    bit lvl;

    function automatic void model_reset();
        m_level = 0;
        hist.delete();
        held    = 0;
        prev_s  = 1'b0;
        exp_lvl = 1'b0;
    endfunction

    function automatic void model_step(bit s);
        bit all_opp;
        exp_np = 0;
        exp_nr = 0;
        hist.push_back(s);
        if (hist.size() > STABLE) void'(hist.pop_front());
        all_opp = (hist.size() == STABLE);
        foreach (hist[i]) if (hist[i] == m_level[0]) all_opp = 1'b0;
        if (all_opp) begin
            m_level = 1 - m_level;
            if (m_level == 1) exp_np = 1;
            else              exp_nr = 1;
            hist.delete();
            held = 0;
        end
`ifdef AUTO_REPEAT_EN
        // While accepted-high, a tick counts as "held" when it and the one
        // before both sampled 1 (a bounce back resets nothing, just pauses)
        else if (m_level == 1 && s && prev_s) begin
            held = held + 1;
            if (held == DELAY || (held > DELAY && (held - DELAY) % RATE == 0))
                exp_np = 1;
        end
`endif
        prev_s  = s;
        exp_lvl = m_level[0];
    endfunction

    // One full clk_deb period with btn_in set well before the rising edge
    task automatic tick_step(input bit b, output int o_np, output int o_nr, output bit o_lvl);
        int p0;
        int r0;
        @(negedge clk);
        #1;
        btn_in  = b;
        clk_deb = 1'b0;
        p0 = tot_press;
        r0 = tot_rel;
        repeat (7) @(negedge clk);
        #1;
        clk_deb = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        o_np  = tot_press - p0;
        o_nr  = tot_rel - r0;
        o_lvl = btn_level;
    endtask

    task automatic test_reset();
        int p0;
        int r0;
        n_checks++;
        if ({btn_level, btn_press, btn_release} !== 3'b000) begin
            $display("FAIL reset_state: got lvl/press/rel=%b want 000",
                     {btn_level, btn_press, btn_release});
        end else n_pass++;

        // Button held and clk_deb running while reset is asserted
        p0 = tot_press;
        r0 = tot_rel;
        for (int i = 0; i < 5; i++) tick_step(1'b1, np, nr, lvl);
        n_checks++;
        if (tot_press - p0 !== 0 || tot_rel - r0 !== 0 || lvl !== 1'b0) begin
            $display("FAIL reset_hold: got press=%0d rel=%0d lvl=%0b want 0 0 0",
                     tot_press - p0, tot_rel - r0, lvl);
        end else n_pass++;

        @(negedge clk);
        clk_deb = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick_step(1'b1, np, nr, lvl);
            model_step(1'b1);
            n_checks++;
            if (np !== exp_np || nr !== exp_nr || lvl !== exp_lvl) begin
                $display("FAIL reset_accept t%0d: got press=%0d rel=%0d lvl=%0b want %0d %0d %0b",
                         i, np, nr, lvl, exp_np, exp_nr, exp_lvl);
            end else n_pass++;
        end
    endtask

    task automatic test_abort();
        int p0;
        int r0;
        // Return to released first
        for (int i = 0; i < 5; i++) begin
            tick_step(1'b0, np, nr, lvl);
            model_step(1'b0);
        end
        tick_step(1'b1, np, nr, lvl);
        tick_step(1'b1, np, nr, lvl);
        @(negedge clk);
        rst_n = 1'b0;
        p0 = tot_press;
        r0 = tot_rel;
        for (int i = 0; i < 3; i++) tick_step(1'b1, np, nr, lvl);
        @(negedge clk);
        clk_deb = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (tot_press - p0 !== 0 || tot_rel - r0 !== 0 || btn_level !== 1'b0) begin
            $display("FAIL abort_in_reset: got press=%0d rel=%0d lvl=%0b want 0 0 0",
                     tot_press - p0, tot_rel - r0, btn_level);
        end else n_pass++;
        rst_n = 1'b1;
        model_reset();
        // Count must restart from zero: press only on the 4th tick
        for (int i = 0; i < 4; i++) begin
            tick_step(1'b1, np, nr, lvl);
            model_step(1'b1);
            n_checks++;
            if (np !== exp_np || nr !== exp_nr || lvl !== exp_lvl || np !== (i == 3 ? 1 : 0)) begin
                $display("FAIL abort_restart t%0d: got press=%0d rel=%0d lvl=%0b want %0d %0d %0b",
                         i, np, nr, lvl, exp_np, exp_nr, exp_lvl);
            end else n_pass++;
        end
    endtask

    task automatic test_press_release();
        bit seq[12];
        seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        // Start from a clean released state
        for (int i = 0; i < 5; i++) begin
            tick_step(1'b0, np, nr, lvl);
            model_step(1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            tick_step(seq[i], np, nr, lvl);
            model_step(seq[i]);
            n_checks++;
            if (np !== exp_np || nr !== exp_nr || lvl !== exp_lvl) begin
                $display("FAIL press_release t%0d: got press=%0d rel=%0d lvl=%0b want %0d %0d %0b",
                         i, np, nr, lvl, exp_np, exp_nr, exp_lvl);
            end else n_pass++;
        end
    endtask

    task automatic test_bounce_press();
        bit seq[8];
        int presses;
        int at;
        seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            tick_step(1'b0, np, nr, lvl);
            model_step(1'b0);
        end
        presses = 0;
        at = -1;
        for (int i = 0; i < 8; i++) begin
            tick_step(seq[i], np, nr, lvl);
            model_step(seq[i]);
            presses += np;
            if (np != 0) at = i;
            n_checks++;
            if (np !== exp_np || nr !== exp_nr || lvl !== exp_lvl) begin
                $display("FAIL bounce_press t%0d: got press=%0d rel=%0d lvl=%0b want %0d %0d %0b",
                         i, np, nr, lvl, exp_np, exp_nr, exp_lvl);
            end else n_pass++;
        end
        n_checks++;
        if (presses !== 1 || at !== 7) begin
            $display("FAIL bounce_single: got %0d presses at tick %0d want 1 at tick 7", presses, at);
        end else n_pass++;
    endtask

    task automatic test_glitch_hold();
        bit seq[6];
        int rels;
        seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rels = 0;
        for (int i = 0; i < 6; i++) begin
            tick_step(seq[i], np, nr, lvl);
            model_step(seq[i]);
            rels += nr;
            n_checks++;
            if (np !== exp_np || nr !== exp_nr || lvl !== exp_lvl || lvl !== 1'b1) begin
                $display("FAIL glitch_hold t%0d: got press=%0d rel=%0d lvl=%0b want %0d %0d 1",
                         i, np, nr, lvl, exp_np, exp_nr);
            end else n_pass++;
        end
        n_checks++;
        if (rels !== 0) begin
            $display("FAIL glitch_no_release: got %0d release pulses want 0", rels);
        end else n_pass++;
    endtask

    task automatic test_stuck_deb();
        int p0;
        int r0;
        bit l0;
        for (int phase = 0; phase < 2; phase++) begin
            @(negedge clk);
            clk_deb = phase[0];
            l0 = btn_level;
            p0 = tot_press;
            r0 = tot_rel;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (c % 3 == 0) btn_in = ~btn_in;
            end
            #1;
            n_checks++;
            if (tot_press - p0 !== 0 || tot_rel - r0 !== 0 || btn_level !== l0
                || btn_level !== exp_lvl) begin
                $display("FAIL stuck_deb_%0d: got press=%0d rel=%0d lvl=%0b want 0 0 %0b",
                         phase, tot_press - p0, tot_rel - r0, btn_level, exp_lvl);
            end else n_pass++;
        end
    endtask

    task automatic test_auto_repeat();
        int got[$];
        int want[$];
        int t;
        int bad;
        for (int i = 0; i < 5; i++) begin
            tick_step(1'b0, np, nr, lvl);
            model_step(1'b0);
        end
        // Accept tick is index 0, then 60 held ticks
        t = -1;
        for (int i = 0; i < 8 && t < 0; i++) begin
            tick_step(1'b1, np, nr, lvl);
            model_step(1'b1);
            if (np != 0) begin
                t = 0;
                got.push_back(0);
            end
        end
        n_checks++;
        if (t !== 0) begin
            $display("FAIL repeat_accept: got no press within 8 ticks want one");
        end else n_pass++;
        bad = 0;
        for (int i = 1; i <= 60; i++) begin
            tick_step(1'b1, np, nr, lvl);
            model_step(1'b1);
            if (np != 0) got.push_back(i);
            if (nr != 0 || lvl != 1'b1) bad++;
        end
`ifdef AUTO_REPEAT_EN
        want = '{0, 32, 40, 48, 56};
`else
        want = '{0};
`endif
        n_checks++;
        if (got.size() !== want.size() || bad !== 0) begin
            $display("FAIL repeat_count: got %0d presses (%0d bad ticks) want %0d presses",
                     got.size(), bad, want.size());
        end else n_pass++;
        for (int k = 0; k < want.size() && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== want[k]) begin
                $display("FAIL repeat_pos%0d: got tick %0d want tick %0d", k, got[k], want[k]);
            end else n_pass++;
        end
    endtask

    task automatic test_random();
        bit b;
        b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) b = ~b;
            tick_step(b, np, nr, lvl);
            model_step(b);
            n_checks++;
            if (np !== exp_np || nr !== exp_nr || lvl !== exp_lvl) begin
                $display("FAIL random t%0d: got press=%0d rel=%0d lvl=%0b want %0d %0d %0b",
                         i, np, nr, lvl, exp_np, exp_nr, exp_lvl);
            end else n_pass++;
        end
        n_checks++;
        if (both_hi !== 0) begin
            $display("FAIL both_pulses: got %0d cycles with press and release high want 0", both_hi);
        end else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        clk_deb  = 1'b0;
        btn_in   = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_abort();
        test_press_release();
        test_bounce_press();
        test_glitch_hold();
        test_stuck_deb();
        test_auto_repeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
